// File: rtl/xor_frame_parity_pkg.sv
// Shared definitions for the frame column-parity block: state encoding and a
// saturating-increment helper used by the beat counter.
package xor_frame_parity_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to idle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int unsigned STATE_W = 2;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    logic [31:0] result;
    if (value >= max_val) begin
      result = max_val;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xor_frame_parity_reduce.sv
// Combinational XOR reduction of a word to one parity bit; reused by later
// parity blocks.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  always_comb begin
    par = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      par = par ^ data[i];
    end
  end

endmodule

// File: rtl/xor_frame_parity.sv
// Accumulates the column parity (bitwise XOR) of a multi-beat frame and
// presents one result per frame with overall parity and a saturating beat count.
module xor_frame_parity
  import xor_frame_parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  // Valid/ready: a transfer happens on a rising edge where valid && ready;
  // valid-side payload is ignored otherwise, and ready never depends on valid.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_col,
  output logic             out_par,
  output logic [CNT_W-1:0] out_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             col_par;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // The first beat of a frame loads rather than folds, so no separate clear is needed.
  always_comb begin
    acc_next = acc ^ in_data;
    cnt_next = CNT_W'(sat_inc(32'(cnt), CNT_MAX));
    if (state == S_IDLE) begin
      acc_next = in_data;
      cnt_next = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_cnt   <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (in_last) begin
              // Result registers capture the value including the final beat.
              state     <= S_HOLD;
              out_col   <= acc_next;
              out_cnt   <= cnt_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  xor_reduce #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .data(out_col),
    .par (col_par)
  );

  assign out_par = col_par ^ ODD;

endmodule

// File: tb/tb_xor_frame_parity.sv
// Bench for xor_frame_parity: two instances share one input stream (8-bit count
// even parity, and 2-bit count odd parity) and are checked against expected queues.
module tb_xor_frame_parity;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_par_a;
  logic [7:0] out_col_a, out_cnt_a;
  logic [1:0] dbg_state_a;
  logic       in_ready_b, out_valid_b, out_par_b;
  logic [7:0] out_col_b;
  logic [1:0] out_cnt_b;
  logic [1:0] dbg_state_b;

  // Packed expectation: {col[7:0], par, cnt[7:0]}
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];

  int checks   = 0;
  int failures = 0;
  bit rand_or  = 0;

  xor_frame_parity #(.WIDTH(8), .CNT_W(8), .ODD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_col(out_col_a), .out_par(out_par_a),
    .out_cnt(out_cnt_a), .dbg_state(dbg_state_a)
  );

  xor_frame_parity #(.WIDTH(8), .CNT_W(2), .ODD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_col(out_col_b), .out_par(out_par_b),
    .out_cnt(out_cnt_b), .dbg_state(dbg_state_b)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entries for both instances; par_even is the hand-computed XOR of all bits.
  task automatic push_exp(input logic [7:0] col, input logic par_even, input int cnt);
    int cnt_b;
    cnt_b = (cnt > 3) ? 3 : cnt;
    exp_q_a.push_back({col, par_even, 8'(cnt)});
    exp_q_b.push_back({col, ~par_even, 8'(cnt_b)});
  endtask

  // Scoreboard monitors: pop on the rising of out_valid, then require stability while held.
  logic [16:0] held_a, held_b;
  bit taken_a = 0, taken_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      taken_a = 0;
    end else if (out_valid_a) begin
      if (!taken_a) begin
        if (exp_q_a.size() == 0) begin
          chk("a_unexpected_result", 32'(out_col_a), 32'hFFFF_FFFF);
        end else begin
          held_a = exp_q_a.pop_front();
          chk("a_col", 32'(out_col_a), 32'(held_a[16:9]));
          chk("a_par", 32'(out_par_a), 32'(held_a[8]));
          chk("a_cnt", 32'(out_cnt_a), 32'(held_a[7:0]));
        end
        taken_a = 1;
      end else begin
        chk("a_hold_stable", 32'({out_col_a, out_par_a, out_cnt_a}), 32'(held_a));
        chk("a_hold_in_ready", 32'(in_ready_a), 32'd0);
      end
    end else begin
      taken_a = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      taken_b = 0;
    end else if (out_valid_b) begin
      if (!taken_b) begin
        if (exp_q_b.size() == 0) begin
          chk("b_unexpected_result", 32'(out_col_b), 32'hFFFF_FFFF);
        end else begin
          held_b = exp_q_b.pop_front();
          chk("b_col", 32'(out_col_b), 32'(held_b[16:9]));
          chk("b_par", 32'(out_par_b), 32'(held_b[8]));
          chk("b_cnt", 32'(out_cnt_b), 32'(held_b[7:0]));
        end
        taken_b = 1;
      end else begin
        chk("b_hold_stable", 32'({out_col_b, out_par_b, 6'd0, out_cnt_b}),
            32'({held_b[16:8], held_b[7:0]}));
        chk("b_hold_in_ready", 32'(in_ready_b), 32'd0);
      end
    end else begin
      taken_b = 0;
    end
  end

  // Random consumer back-pressure, enabled only for the random-frame section.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Driver tasks: called at a negedge, return at the negedge after the beat is taken.
  task automatic drive_beat(input logic [7:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_a && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("in_ready_timeout", 32'(in_ready_a), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || out_valid_a) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_q_a", 32'(exp_q_a.size()), 32'd0);
    chk("drain_q_b", 32'(exp_q_b.size()), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid_a), 32'd0);
    chk({tag, "_out_col"},   32'(out_col_a),   32'd0);
    chk({tag, "_out_cnt"},   32'(out_cnt_a),   32'd0);
    chk({tag, "_in_ready"},  32'(in_ready_a),  32'd1);
    chk({tag, "_out_par_a"}, 32'(out_par_a),   32'd0);
    chk({tag, "_out_par_b"}, 32'(out_par_b),   32'd1);
    chk({tag, "_state"},     32'(dbg_state_a), 32'd0);
    chk({tag, "_valid_b"},   32'(out_valid_b), 32'd0);
  endtask

  logic [7:0] words[8];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    chk_reset_values("reset");
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready_a), 32'd1);

    // Single-beat frame.
    out_ready = 1'b1;
    push_exp(8'hA5, 1'b0, 1);
    drive_beat(8'hA5, 1'b1);
    idle(2);

    // Three-beat frame held by the consumer for four cycles.
    out_ready = 1'b0;
    push_exp(8'hF1, 1'b1, 3);
    drive_beat(8'hFF, 1'b0);
    drive_beat(8'h0F, 1'b0);
    drive_beat(8'h01, 1'b1);
    idle(4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_handshake_in_ready", 32'(in_ready_a), 32'd1);
    chk("after_handshake_out_valid", 32'(out_valid_a), 32'd0);

    // Gapped four-beat frame, then the same frame gap-free back-to-back.
    push_exp(8'h08, 1'b1, 4);
    drive_beat(8'h12, 1'b0); idle(1);
    drive_beat(8'h34, 1'b0); idle(1);
    drive_beat(8'h56, 1'b0); idle(1);
    drive_beat(8'h78, 1'b1);
    push_exp(8'h08, 1'b1, 4);
    drive_beat(8'h12, 1'b0);
    drive_beat(8'h34, 1'b0);
    drive_beat(8'h56, 1'b0);
    drive_beat(8'h78, 1'b1);

    // Six-beat frame saturates the 2-bit counter of the second instance.
    push_exp(8'h3F, 1'b0, 6);
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h04, 1'b0);
    drive_beat(8'h08, 1'b0);
    drive_beat(8'h10, 1'b0);
    drive_beat(8'h20, 1'b1);
    drain();

    // Random frames with gaps and consumer back-pressure.
    rand_or = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      logic [7:0] col;
      len = $urandom_range(1, 8);
      col = 8'h00;
      for (int b = 0; b < len; b++) begin
        words[b] = 8'($urandom_range(0, 255));
        col      = col ^ words[b];
      end
      push_exp(col, ^col, len);
      for (int b = 0; b < len; b++) begin
        drive_beat(words[b], (b == len - 1));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_or = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Leave a nonzero result registered, then reset asynchronously mid-frame.
    push_exp(8'h5A, 1'b0, 1);
    drive_beat(8'h5A, 1'b1);
    drain();
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(8'h3C, 1'b0, 1);
    drive_beat(8'h3C, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
